// File: rtl/multiword_add_seq.sv
// Operand sequencer / result collector wrapped around an external 32-bit ripple adder.
// Optional subtract mode (in_sub port, inverted B, initial carry 1) is enabled by defining MWADD_SUB_EN.
`timescale 1ns/1ps
module multiword_add_seq #(
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,
`ifdef MWADD_SUB_EN
  input  logic        in_sub,
`endif
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_c_in,
  input  logic [31:0] add_sum,
  input  logic        add_c_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_last,
  output logic        out_carry,
  output logic        out_ovf,
  output logic        out_zero,
  output logic        out_err
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [0:0] {S_IDLE, S_ACTIVE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // S1: operand stage
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic        s1_v_q, s1_v_d;

  // Inter-word chaining state
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;

  // S2: output stage
  logic        ov_q, ov_d;
  logic [31:0] osum_q, osum_d;
  logic        olast_q, olast_d;
  logic        ocarry_q, ocarry_d;
  logic        oovf_q, oovf_d;
  logic        ozero_q, ozero_d;
  logic        oerr_q, oerr_d;

  logic          adv, accept, drain, first, trunc, sum_zero, init_c;
  logic [CW-1:0] cnt_nxt;

`ifdef MWADD_SUB_EN
  logic sub_q, sub_d;

  always_comb begin
    sub_d  = sub_q;
    if (accept && first) sub_d = in_sub;
    add_b  = sub_q ? ~b_q : b_q;
    init_c = in_sub;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sub_q <= 1'b0;
    else        sub_q <= sub_d;
  end
`else
  always_comb begin
    add_b  = b_q;
    init_c = 1'b0;
  end
`endif

  always_comb begin
    add_a    = a_q;
    add_c_in = carry_q;
    sum_zero = (add_sum == '0);
    adv      = !ov_q || out_ready;
    in_ready = !s1_v_q || adv;
    accept   = in_valid && in_ready;
    drain    = adv && s1_v_q;
    first    = (state_q == S_IDLE);
    // Count rests at 0 in IDLE, so the first beat naturally becomes word 1.
    cnt_nxt  = cnt_q + CW'(1);
    trunc    = (cnt_nxt == CW'(MAX_WORDS));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    last_d   = last_q;
    err_d    = err_q;
    s1_v_d   = s1_v_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ov_d     = ov_q;
    osum_d   = osum_q;
    olast_d  = olast_q;
    ocarry_d = ocarry_q;
    oovf_d   = oovf_q;
    ozero_d  = ozero_q;
    oerr_d   = oerr_q;

    if (adv) begin
      ov_d = s1_v_q;
    end

    if (drain) begin
      osum_d   = add_sum;
      olast_d  = last_q;
      ocarry_d = last_q && add_c_out;
      ozero_d  = last_q && zero_q && sum_zero;
      oovf_d   = last_q && (a_q[31] == add_b[31]) && (add_sum[31] != a_q[31]);
      oerr_d   = last_q && err_q;
      carry_d  = add_c_out;
      zero_d   = zero_q && sum_zero;
      s1_v_d   = 1'b0;
    end

    if (accept) begin
      a_d    = in_a;
      b_d    = in_b;
      last_d = in_last || trunc;
      err_d  = trunc && !in_last;
      s1_v_d = 1'b1;
      // A first beat can only be accepted alongside the previous op's final drain, so it wins.
      if (first) begin
        carry_d = init_c;
        zero_d  = 1'b1;
      end
      if (in_last || trunc) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_ACTIVE;
        cnt_d   = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      s1_v_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ov_q     <= 1'b0;
      osum_q   <= '0;
      olast_q  <= 1'b0;
      ocarry_q <= 1'b0;
      oovf_q   <= 1'b0;
      ozero_q  <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      last_q   <= last_d;
      err_q    <= err_d;
      s1_v_q   <= s1_v_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ov_q     <= ov_d;
      osum_q   <= osum_d;
      olast_q  <= olast_d;
      ocarry_q <= ocarry_d;
      oovf_q   <= oovf_d;
      ozero_q  <= ozero_d;
      oerr_q   <= oerr_d;
    end
  end

  always_comb begin
    out_valid = ov_q;
    out_sum   = osum_q;
    out_last  = olast_q;
    out_carry = ocarry_q;
    out_ovf   = oovf_q;
    out_zero  = ozero_q;
    out_err   = oerr_q;
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq; models the external 32-bit adder and collects results at negedge.
`timescale 1ns/1ps
module tb_multiword_add_seq;

  localparam int unsigned MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, in_sub;
  logic [31:0] in_a, in_b;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_c_in, add_c_out;
  logic        out_valid, out_ready, out_last, out_carry, out_ovf, out_zero, out_err;
  logic [31:0] out_sum;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        last;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        err;
  } res_t;

  res_t rq[$];

  always #5 clk = ~clk;

  assign {add_c_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c_in};

  multiword_add_seq #(.MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
`ifdef MWADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c_in  (add_c_in),
    .add_sum   (add_sum),
    .add_c_out (add_c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always @(negedge clk) begin
    res_t r;
    if (rst_n && out_valid && out_ready) begin
      r.sum   = out_sum;
      r.last  = out_last;
      r.carry = out_carry;
      r.ovf   = out_ovf;
      r.zero  = out_zero;
      r.err   = out_err;
      rq.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last, input logic sub);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_sub   = sub;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("send_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_res(input int n, input string tag);
    int k = 0;
    while (rq.size() < n && k < 200) begin
      step();
      k++;
    end
    chk(tag, rq.size(), n);
  endtask

  task automatic chk_res(input int i, input string tag, input logic [31:0] sum, input logic last,
                         input logic carry, input logic ovf, input logic zero, input logic err);
    res_t r;
    r = '0;
    if (i < rq.size()) r = rq[i];
    chk({tag, ".sum"},   r.sum,   sum);
    chk({tag, ".last"},  r.last,  last);
    chk({tag, ".carry"}, r.carry, carry);
    chk({tag, ".ovf"},   r.ovf,   ovf);
    chk({tag, ".zero"},  r.zero,  zero);
    chk({tag, ".err"},   r.err,   err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst.in_ready",  in_ready,  1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_sum",   out_sum,   0);
    chk("rst.flags", {out_last, out_carry, out_ovf, out_zero, out_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 64-bit add with carry across words
    rq.delete();
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    send(32'h00000000, 32'h00000000, 1'b1, 1'b0);
    idle();
    wait_res(2, "a64.count");
    chk_res(0, "a64.w0", 32'h00000000, 0, 0, 0, 0, 0);
    chk_res(1, "a64.w1", 32'h00000001, 1, 0, 0, 0, 0);

    // Single-word ops back-to-back, with latency check
    rq.delete();
    send(32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
    chk("lat.early", out_valid, 0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
    chk("lat.valid", out_valid, 1);
    chk("lat.sum",   out_sum,   32'h80000000);
    idle();
    wait_res(2, "sw.count");
    chk_res(0, "sw.ovf",  32'h80000000, 1, 0, 1, 0, 0);
    chk_res(1, "sw.zero", 32'h00000000, 1, 1, 0, 1, 0);

    // Output stall on a 4-word stream
    rq.delete();
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_last = 1'b0;
    step();
    in_a = 32'h00000001; in_b = 32'h00000000;
    step();
    out_ready = 1'b0;
    in_a = 32'h80000000; in_b = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", i),  in_ready,  0);
      chk($sformatf("stall%0d.out_valid", i), out_valid, 1);
      chk($sformatf("stall%0d.out_sum", i),   out_sum,   32'hFFFFFFFE);
      chk($sformatf("stall%0d.add_a", i),     add_a,     32'h00000001);
      step();
    end
    out_ready = 1'b1;
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0);
    send(32'h12345678, 32'h11111111, 1'b1, 1'b0);
    idle();
    wait_res(4, "stall.count");
    chk_res(0, "stall.w0", 32'hFFFFFFFE, 0, 0, 0, 0, 0);
    chk_res(1, "stall.w1", 32'h00000002, 0, 0, 0, 0, 0);
    chk_res(2, "stall.w2", 32'h00000000, 0, 0, 0, 0, 0);
    chk_res(3, "stall.w3", 32'h2345678A, 1, 0, 0, 0, 0);

    // Truncation at MAX_WORDS; 9th beat opens a fresh operation
    rq.delete();
    for (int i = 0; i < 8; i++) send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle();
    wait_res(9, "trunc.count");
    chk_res(0, "trunc.w0", 32'hFFFFFFFE, 0, 0, 0, 0, 0);
    for (int i = 1; i < 7; i++) chk_res(i, $sformatf("trunc.w%0d", i), 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    chk_res(7, "trunc.w7", 32'hFFFFFFFF, 1, 1, 0, 0, 1);
    chk_res(8, "trunc.new", 32'hFFFFFFFE, 1, 1, 0, 0, 0);

    // Reset mid-operation
    rq.delete();
    send(32'h00000001, 32'h00000000, 1'b0, 1'b0);
    send(32'h00000002, 32'h00000000, 1'b0, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", out_valid, 0);
    chk("mrst.out_sum",   out_sum,   0);
    chk("mrst.in_ready",  in_ready,  1);
    chk("mrst.flags", {out_last, out_carry, out_ovf, out_zero, out_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rq.delete();
    send(32'h00000001, 32'h00000001, 1'b1, 1'b0);
    idle();
    wait_res(1, "mrst.count");
    chk_res(0, "mrst.add", 32'h00000002, 1, 0, 0, 0, 0);

`ifdef MWADD_SUB_EN
    rq.delete();
    send(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    send(32'h00000007, 32'h00000005, 1'b1, 1'b1);
    idle();
    wait_res(2, "sub.count");
    chk_res(0, "sub.neg", 32'hFFFFFFFE, 1, 0, 0, 0, 0);
    chk_res(1, "sub.pos", 32'h00000002, 1, 1, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Operand sequencer and result collector for multi-precision addition built on the team's 32-bit ripple adder (`B32Bit_adder`). It accepts operand word pairs least-significant word first over a valid/ready stream and drives the adder's `A`, `B` and `c_in` from registered operands. It chains `c_out` of word k into `c_in` of word k+1 through a carry register, and emits each 32-bit sum word on an output stream with end-of-operation flags. One word per cycle sustained; the adder instance sits outside this block, between its `add_*` ports.

## Interface
- `MAX_WORDS`, default 8: maximum words per operation (≥2); beat MAX_WORDS is forced to be last.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts beat this cycle.
- `in_a`  in  32  operand A word.
- `in_b`  in  32  operand B word.
- `in_last`  in  1  beat is most-significant word.
- `in_sub`  in  1  subtract (B inverted); present only with `MWADD_SUB_EN`; sampled on first beat only.
- `add_a`  out  32  to adder `A`.
- `add_b`  out  32  to adder `B`.
- `add_c_in`  out  1  to adder `c_in`.
- `add_sum`  in  32  from adder `sum`.
- `add_c_out`  in  1  from adder `c_out`.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  32  result word.
- `out_last`  out  1  final word of operation.
- `out_carry`  out  1  final carry-out; 0 when `out_last`=0.
- `out_ovf`  out  1  two's-complement overflow of full-width result; 0 when `out_last`=0.
- `out_zero`  out  1  every word of result is zero; 0 when `out_last`=0.
- `out_err`  out  1  operation truncated at MAX_WORDS; 0 when `out_last`=0.

## Operation
- Two register stages:
  - S1 holds operand beat (`a_q`, `b_q`, `last_q`, `s1_v`).
  - S2 is the output register.
- The adder path between them is combinational.
- `add_a`=`a_q`; `add_b`=`b_q` (or `~b_q` when subtracting); `add_c_in`=`carry_q`.
- `adv` = `!out_valid || out_ready`. `in_ready` = `!s1_v || adv`.
- On `adv && s1_v` (S1→S2):
  - S2 captures `add_sum` and `last_q`.
  - `carry_q` <= `add_c_out`.
  - `zero_q` <= `zero_q && (add_sum==0)`.
- Flags on the last word:
  - `out_carry`=`add_c_out`.
  - `out_zero`=`zero_q && (add_sum==0)`.
  - `out_ovf`=`(a_q[31]==add_b[31]) && (add_sum[31]!=a_q[31])`.
- FSM:
  - IDLE: next beat is first word. Accepting a beat loads `carry_q` = initial carry (0; 1 when subtracting), sets `zero_q`=1 and word count=1. Go to ACTIVE unless `in_last`.
  - ACTIVE: each accepted beat increments count. Accepting a beat with `in_last`=1, or accepting beat MAX_WORDS, returns to IDLE.
- Truncation: beat MAX_WORDS with `in_last`=0 is treated as last, and `out_err`=1 on that result.
- The initial carry is applied when the beat enters S1, so a new operation may follow a last word back-to-back with no bubble.
- Simultaneous S2 drain and S1 refill in one cycle is legal.
- Simultaneous S1 drain and new beat accept in one cycle is legal.
- Neither case produces a bubble.
- `add_*` outputs are don't-care while `s1_v`=0, but must be held stable (no toggling) while S1 is stalled.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_sum`=0.
  - All flags 0.
  - `carry_q`=0, `s1_v`=0, count 0, FSM IDLE.
- Reset mid-operation discards S1, S2 and the partial carry. The next beat starts a new operation.
- Latency: a beat accepted at edge N produces its result with `out_valid` high after edge N+1 when the output is unstalled.
- Throughput: 1 word/cycle.
- Handshake:
  - Transfer occurs when valid && ready.
  - `out_*` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- `in_ready` depends combinationally on `out_ready`; there is no other combinational in→out path except through the adder.

## Configuration
- `MWADD_SUB_EN` defined:
  - `in_sub` port exists.
  - On a subtract operation every word uses `add_b`=`~b_q`, and the first word uses `add_c_in`=1.
  - `out_carry`=1 means no borrow.
- `MWADD_SUB_EN` undefined:
  - No `in_sub` port.
  - `add_b`=`b_q` always; initial carry 0.

## Test plan
- 64-bit add, words (A,B) = (FFFFFFFF,00000001) then last (00000000,00000000) → out 00000000 (last 0), then 00000001 (last 1), carry 0, ovf 0, zero 0.
- Single-word add, 7FFFFFFF+00000001 with last → 80000000, ovf 1, carry 0, zero 0; FFFFFFFF+00000001 → 00000000, carry 1, zero 1.
- Stall: 4-word stream, `out_ready` low 3 cycles after first result → `in_ready` low once S1 fills, `out_sum` held, all 4 words delivered in order with correct carries.
- Truncation: MAX_WORDS=8, 9 beats with `in_last`=0 → 8th result has last 1 and err 1; 9th beat starts a new operation with carry 0.
- `MWADD_SUB_EN`: single word 00000005−00000007 → FFFFFFFE, carry 0; 00000007−00000005 → 00000002, carry 1.
- Reset asserted after word 2 of 4 → outputs return to reset values immediately; the next operation 1+1 yields 00000002.
